// File: rtl/freq_meter_bcd.sv
// Gated frequency meter: counts synchronised rising edges of fin over a gate of
// 1/10/100-fraction of GATE_MAX ce ticks and latches the count as packed BCD.
module freq_meter_bcd #(
  parameter int DIGITS      = 4,
  parameter int GATE_MAX    = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  fin,
  input  logic                  auto,
  input  logic [1:0]            range_in,
  input  logic                  hold,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [1:0]            range_out,
  output logic                  ovf,
  output logic                  valid,
  output logic [1:0]            state_dbg
);

  localparam int W  = 4 * DIGITS;
  localparam int GW = $clog2(GATE_MAX + 1);
  localparam logic [GW-1:0] LAST0 = GW'(GATE_MAX - 1);
  localparam logic [GW-1:0] LAST1 = GW'(GATE_MAX / 10 - 1);
  localparam logic [GW-1:0] LAST2 = GW'(GATE_MAX / 100 - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GATE = 2'd1, S_LATCH = 2'd2} state_t;

  // valid is a single-cycle strobe with no back-pressure: bcd_out, range_out and
  // ovf change only in the cycle valid is high and must be taken then.

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   edge_q, edge_d;
  logic [W-1:0]           cnt_q, cnt_d;
  logic                   ovf_flag_q, ovf_flag_d;
  logic [GW-1:0]          gate_cnt_q, gate_cnt_d;
  logic [1:0]             act_range_q, act_range_d;
  logic [1:0]             auto_range_q, auto_range_d;
  logic [W-1:0]           bcd_q, bcd_d;
  logic [1:0]             range_out_q, range_out_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;

  logic [W-1:0]           cnt_inc;
  logic                   all_nines;
  logic                   carry;
  logic [GW-1:0]          gate_last;
  logic [1:0]             range_sel;

  // Ripple the +1 through the digits in one cycle.
  always_comb begin
    cnt_inc   = cnt_q;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (cnt_q[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    case (act_range_q)
      2'd0:    gate_last = LAST0;
      2'd1:    gate_last = LAST1;
      default: gate_last = LAST2;
    endcase
    range_sel = (range_in == 2'd3) ? 2'd2 : range_in;
  end

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[SYNC_STAGES-2:0], fin};
    prev_d       = sync_q[SYNC_STAGES-1];
    edge_d       = sync_q[SYNC_STAGES-1] & ~prev_q;
    cnt_d        = cnt_q;
    ovf_flag_d   = ovf_flag_q;
    gate_cnt_d   = gate_cnt_q;
    act_range_d  = act_range_q;
    auto_range_d = auto_range_q;
    bcd_d        = bcd_q;
    range_out_d  = range_out_q;
    ovf_d        = ovf_q;
    valid_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ce) begin
          cnt_d       = '0;
          ovf_flag_d  = 1'b0;
          gate_cnt_d  = '0;
          act_range_d = auto ? auto_range_q : range_sel;
          state_d     = S_GATE;
        end
      end
      S_GATE: begin
        if (edge_q) begin
          if (all_nines) ovf_flag_d = 1'b1;
          else           cnt_d      = cnt_inc;
        end
        if (ce) begin
          if (gate_cnt_q == gate_last) state_d    = S_LATCH;
          else                         gate_cnt_d = gate_cnt_q + GW'(1);
        end
      end
      S_LATCH: begin
        if (!hold) begin
          bcd_d       = cnt_q;
          ovf_d       = ovf_flag_q;
          range_out_d = act_range_q;
          valid_d     = 1'b1;
        end
        // Range adaptation runs even while the display is held.
        if (!auto)                                         auto_range_d = act_range_q;
        else if (ovf_flag_q && act_range_q < 2'd2)         auto_range_d = act_range_q + 2'd1;
        else if (cnt_q[W-1 -: 4] == 4'd0 && act_range_q != 2'd0) auto_range_d = act_range_q - 2'd1;
        else                                               auto_range_d = act_range_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      edge_q       <= 1'b0;
      cnt_q        <= '0;
      ovf_flag_q   <= 1'b0;
      gate_cnt_q   <= '0;
      act_range_q  <= 2'd0;
      auto_range_q <= 2'd0;
      bcd_q        <= '0;
      range_out_q  <= 2'd0;
      ovf_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      edge_q       <= edge_d;
      cnt_q        <= cnt_d;
      ovf_flag_q   <= ovf_flag_d;
      gate_cnt_q   <= gate_cnt_d;
      act_range_q  <= act_range_d;
      auto_range_q <= auto_range_d;
      bcd_q        <= bcd_d;
      range_out_q  <= range_out_d;
      ovf_q        <= ovf_d;
      valid_q      <= valid_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign range_out = range_out_q;
  assign ovf       = ovf_q;
  assign valid     = valid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Bench for freq_meter_bcd: a 4-digit and a 2-digit meter share stimulus and are
// checked every cycle against an integer gate-window model plus literal results.
module tb_freq_meter_bcd;

  localparam int GATE_MAX = 100;
  localparam int S        = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        fin = 1'b0;
  logic        auto_i = 1'b0;
  logic        hold = 1'b0;
  logic [1:0]  range_in = 2'd0;
  logic [15:0] bcd4;
  logic [7:0]  bcd2;
  logic [1:0]  rng4, rng2, st4, st2;
  logic        ovf4, ovf2, val4, val2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ce_cyc = 0;
  int fin_half = 20;

  freq_meter_bcd #(.DIGITS(4), .GATE_MAX(GATE_MAX), .SYNC_STAGES(S)) u_d4 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .fin(fin), .auto(auto_i), .range_in(range_in),
    .hold(hold), .bcd_out(bcd4), .range_out(rng4), .ovf(ovf4), .valid(val4), .state_dbg(st4)
  );
  freq_meter_bcd #(.DIGITS(2), .GATE_MAX(GATE_MAX), .SYNC_STAGES(S)) u_d2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .fin(fin), .auto(auto_i), .range_in(range_in),
    .hold(hold), .bcd_out(bcd2), .range_out(rng2), .ovf(ovf2), .valid(val2), .state_dbg(st2)
  );

  // ---------------- clock / time base / fin generator ----------------
  always #5 clk = ~clk;

  initial begin
    int cecnt = 0;
    forever begin
      @(negedge clk);
      cecnt = (cecnt == 9) ? 0 : cecnt + 1;
      ce = (cecnt == 9);
    end
  end

  initial begin
    int fcnt = 0;
    forever begin
      @(negedge clk);
      fcnt++;
      if (fcnt >= fin_half) begin
        fin  = ~fin;
        fcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (ce) ce_cyc = cyc;
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: run exceeded cycle limit, got cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // Each meter opens a window on a ce while idle, counts edge pulses in the
  // window (open ce excluded, closing ce included) and shows the saturated
  // count one cycle after the window closes.
  bit          hist[$];
  bit          m_in_gate[2], m_latch_next[2];
  int          m_cnt[2], m_ticks[2], m_rng[2], m_ar[2];
  logic [31:0] exp_bcd[2];
  logic [1:0]  exp_rng[2];
  logic        exp_ovf[2], exp_valid[2];
  int          maxv[2] = '{9999, 99};

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    int x = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int glen(input int r);
    return GATE_MAX / ((r == 0) ? 1 : (r == 1) ? 10 : 100);
  endfunction

  task automatic reset_model();
    hist.delete();
    for (int k = 0; k < S + 3; k++) hist.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      m_in_gate[i] = 0; m_latch_next[i] = 0; m_cnt[i] = 0; m_ticks[i] = 0;
      m_rng[i] = 0; m_ar[i] = 0;
      exp_bcd[i] = '0; exp_rng[i] = 2'd0; exp_ovf[i] = 1'b0; exp_valid[i] = 1'b0;
    end
  endtask

  task automatic step_model();
    bit e;
    int sat;
    bit o;
    hist.push_front(fin);
    void'(hist.pop_back());
    e = hist[S+1] & ~hist[S+2];
    for (int i = 0; i < 2; i++) begin
      exp_valid[i] = 1'b0;
      if (m_latch_next[i]) begin
        m_latch_next[i] = 0;
        o   = (m_cnt[i] > maxv[i]);
        sat = o ? maxv[i] : m_cnt[i];
        if (!hold) begin
          exp_bcd[i] = to_bcd(sat); exp_ovf[i] = o; exp_rng[i] = 2'(m_rng[i]);
          exp_valid[i] = 1'b1;
        end
        if (!auto_i)                                     m_ar[i] = m_rng[i];
        else if (o && m_rng[i] < 2)                      m_ar[i] = m_rng[i] + 1;
        else if (sat < (maxv[i] + 1) / 10 && m_rng[i] > 0) m_ar[i] = m_rng[i] - 1;
        else                                             m_ar[i] = m_rng[i];
      end else if (m_in_gate[i]) begin
        m_cnt[i] += int'(e);
        if (ce) begin
          m_ticks[i]++;
          if (m_ticks[i] == glen(m_rng[i])) begin
            m_in_gate[i] = 0; m_latch_next[i] = 1;
          end
        end
      end else if (ce) begin
        m_in_gate[i] = 1; m_cnt[i] = 0; m_ticks[i] = 0;
        m_rng[i] = auto_i ? m_ar[i] : ((range_in == 2'd3) ? 2 : int'(range_in));
      end
    end
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) reset_model();
      else        step_model();
    end
  end

  // ---------------- scoreboard helpers ----------------
  function automatic logic [31:0] get_bcd(input int i);
    return (i == 0) ? {16'b0, bcd4} : {24'b0, bcd2};
  endfunction
  function automatic logic [1:0] get_rng(input int i);
    return (i == 0) ? rng4 : rng2;
  endfunction
  function automatic logic get_ovf(input int i);
    return (i == 0) ? ovf4 : ovf2;
  endfunction
  function automatic logic get_val(input int i);
    return (i == 0) ? val4 : val2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_in(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h expected %h..%h", name, cyc, act, lo, hi);
    end
  endtask

  task automatic wait_valid(input int i, input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (get_val(i)) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_valid meter %0d at cyc %0d: no valid within %0d cycles", i, cyc, budget);
    end
  endtask

  // Per-cycle compare of both meters against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk((i == 0) ? "cyc_bcd_d4"   : "cyc_bcd_d2",   get_bcd(i),        exp_bcd[i]);
        chk((i == 0) ? "cyc_range_d4" : "cyc_range_d2", 32'(get_rng(i)),   32'(exp_rng[i]));
        chk((i == 0) ? "cyc_ovf_d4"   : "cyc_ovf_d2",   32'(get_ovf(i)),   32'(exp_ovf[i]));
        chk((i == 0) ? "cyc_valid_d4" : "cyc_valid_d2", 32'(get_val(i)),   32'(exp_valid[i]));
      end
    end
  end

  // ---------------- directed + random driver ----------------
  initial begin
    bit ok;
    int t0, nv, nbad;
    fin_half = 20;
    repeat (5) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_bcd",   get_bcd(i),      32'h0);
      chk("reset_range", 32'(get_rng(i)), 32'h0);
      chk("reset_ovf",   32'(get_ovf(i)), 32'h0);
      chk("reset_valid", 32'(get_val(i)), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Manual range 0, fin period 40 clk.
    wait_valid(0, 1300, ok);
    t0 = cyc;
    chk("s1_valid_after_close", 32'(cyc - ce_cyc), 32'd1);
    chk("s1_bcd_d4",   get_bcd(0), 32'h0025);
    chk("s1_range_d4", 32'(rng4),  32'd0);
    chk("s1_ovf_d4",   32'(ovf4),  32'd0);
    chk("s1_bcd_d2",   get_bcd(1), 32'h25);
    @(negedge clk);
    chk("s1_valid_one_cycle", 32'(val4), 32'd0);
    wait_valid(0, 1300, ok);
    chk("s1_gate_spacing", 32'(cyc - t0), 32'd1010);

    // fin period 4 clk: 2-digit meter saturates.
    fin_half = 2;
    wait_valid(1, 1300, ok);
    wait_valid(1, 1300, ok);
    chk("s2_bcd_d2", get_bcd(1), 32'h99);
    chk("s2_ovf_d2", 32'(ovf2),  32'd1);
    chk("s2_bcd_d4", get_bcd(0), 32'h0250);
    chk("s2_ovf_d4", 32'(ovf4),  32'd0);

    // Auto-range on the 2-digit meter.
    auto_i = 1'b1;
    wait_valid(1, 1300, ok);
    chk("s3a_ovf_d2",   32'(ovf2), 32'd1);
    chk("s3a_range_d2", 32'(rng2), 32'd0);
    wait_valid(1, 1300, ok);
    chk("s3b_range_d2", 32'(rng2), 32'd1);
    chk("s3b_bcd_d2",   get_bcd(1), 32'h25);
    chk("s3b_ovf_d2",   32'(ovf2), 32'd0);
    fin_half = 200;
    wait_valid(1, 400, ok);
    chk("s3c_range_d2", 32'(rng2), 32'd1);
    chk_in("s3c_bcd_d2", int'(get_bcd(1)), 'h00, 'h01);
    wait_valid(1, 1300, ok);
    chk("s3d_range_d2", 32'(rng2), 32'd0);
    chk_in("s3d_bcd_d2", int'(get_bcd(1)), 'h02, 'h03);

    // Hold across two gates.
    auto_i = 1'b0; range_in = 2'd0; fin_half = 20;
    wait_valid(1, 1300, ok);
    wait_valid(1, 1300, ok);
    chk("s4_before_hold", get_bcd(1), 32'h25);
    hold = 1'b1;
    nv = 0; nbad = 0;
    repeat (2100) begin
      @(negedge clk);
      if (val2) nv++;
      if (bcd2 !== 8'h25) nbad++;
    end
    chk("s4_hold_no_valid", 32'(nv),   32'd0);
    chk("s4_hold_frozen",   32'(nbad), 32'd0);
    hold = 1'b0;
    wait_valid(1, 1300, ok);
    chk("s4_after_hold_bcd",   get_bcd(1), 32'h25);
    chk("s4_after_hold_range", 32'(rng2),  32'd0);

    // Reset in the middle of a gate.
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_bcd_d4",   get_bcd(0),   32'h0);
    chk("s5_rst_bcd_d2",   get_bcd(1),   32'h0);
    chk("s5_rst_valid_d4", 32'(val4),    32'd0);
    chk("s5_rst_ovf_d2",   32'(ovf2),    32'd0);
    chk("s5_rst_range_d4", 32'(rng4),    32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    wait_valid(0, 1300, ok);
    chk_in("s5_first_valid_delay", cyc - t0, 1000, 1020);

    // Manual range change mid-gate.
    repeat (300) @(negedge clk);
    range_in = 2'd1;
    wait_valid(0, 1300, ok);
    chk("s6a_range_d4", 32'(rng4),  32'd0);
    chk("s6a_bcd_d4",   get_bcd(0), 32'h0025);
    wait_valid(0, 400, ok);
    chk("s6b_range_d4", 32'(rng4), 32'd1);
    chk_in("s6b_bcd_d4", int'(get_bcd(0)), 'h02, 'h03);

    // Randomised operation, checked by the per-cycle compare.
    for (int it = 0; it < 30; it++) begin
      fin_half = $urandom_range(2, 100);
      auto_i   = 1'($urandom_range(0, 1));
      range_in = 2'($urandom_range(0, 3));
      hold     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst_n = 1'b1;
      end
      repeat ($urandom_range(50, 800)) @(negedge clk);
    end
    hold = 1'b0;
    repeat (1100) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter_bcd.md
# freq_meter_bcd

Parametrised gated frequency meter for the frequency generator/meter board design. It counts rising edges of an asynchronous input over a gate built from the 1 ms clock-enable tick and latches the result as packed BCD for the display multiplexer. Compared with the fixed 1 s / 4-digit meter, it adds:
- configurable digit count;
- three gate ranges (1 s, 0.1 s, 0.01 s) with an optional auto-range mode;
- saturation with an overflow flag;
- a hold input;
- a result-valid strobe.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits in the counter and output (2..8)
- GATE_MAX, 1000, ce ticks per gate in range 0; must be divisible by 100
- SYNC_STAGES, 2, synchroniser flops on fin (>=2)

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- ce  in  1  one-cycle time-base tick (1 ms in the board design)
- fin  in  1  asynchronous measured signal; required f(fin) < f(clk)/4
- auto  in  1  1 = auto-range, 0 = manual range from range_in
- range_in  in  2  manual range: 0 = GATE_MAX, 1 = GATE_MAX/10, 2 = GATE_MAX/100 ticks; 3 behaves as 2
- hold  in  1  1 = freeze outputs, measurement continues
- bcd_out  out  4*DIGITS  latched result, digit 0 in bits [3:0]
- range_out  out  2  range used for the gate that produced bcd_out
- ovf  out  1  bcd_out saturated during that gate
- valid  out  1  one-cycle pulse when bcd_out/range_out/ovf update

## Operation
Input path:
- fin passes through SYNC_STAGES flops.
- A rising-edge detector produces a one-cycle pulse `edge`.

Counter:
- DIGITS-digit BCD up-counter, incremented by `edge`, carry resolved within the cycle.
- At all-nines, a further edge leaves the value at all-nines and sets the internal ovf_flag.

FSM states: IDLE, GATE, LATCH.
- IDLE (reset state). On ce:
  - clear counter and ovf_flag, set gate_cnt = 0;
  - fix the active range (range_in if auto = 0, else auto_range);
  - go to GATE.
- GATE:
  - `edge` pulses are counted;
  - each ce increments gate_cnt;
  - on the ce where gate_cnt = gate_len-1, go to LATCH; edges in that same cycle are counted.
- LATCH (exactly one cycle):
  - if hold = 0: bcd_out <= counter, ovf <= ovf_flag, range_out <= active range, valid <= 1;
  - if hold = 1: outputs unchanged, valid stays 0;
  - auto_range updated (rule below); go to IDLE.
- Gate-to-gate dead time is at most one ce period.

Auto-range rule, applied in LATCH whether or not hold is set:
- ovf_flag = 1 and range < 2 → range+1.
- Else, most-significant digit = 0 and range > 0 → range-1.
- Else unchanged.
- In manual mode auto_range tracks the active range.

Boundary conditions:
- Changes on range_in or auto during GATE take effect at the next gate start.
- ce coincident with `edge` in IDLE: the edge is not counted.
- Reset mid-gate: everything clears immediately, state returns to IDLE, auto_range = 0, partial count discarded.

## Timing
- Reset values: bcd_out = 0, range_out = 0, ovf = 0, valid = 0, state IDLE, auto_range = 0.
- fin rising edge to `edge` pulse: SYNC_STAGES+1 clk cycles.
- Closing ce in cycle T → state LATCH in T+1 → outputs updated and valid = 1 in T+2 only.
- Gate length: exactly gate_len ce ticks, from the opening ce (exclusive) to the closing ce (inclusive).
- Quantisation: ±1 count depending on fin phase.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Bench configuration: GATE_MAX = 100, ce one cycle in every 10 clk, so range 0 = 1000 clk.
- Manual range 0, DIGITS = 4, fin period 40 clk → bcd_out = 0x0025 (±1), ovf = 0, range_out = 0, one valid pulse per gate, valid two cycles after the closing ce.
- DIGITS = 2, manual range 0, fin period 4 clk → bcd_out = 0x99, ovf = 1.
- DIGITS = 2, auto = 1, fin period 4 clk:
  - first gate ovf = 1, range_out = 0;
  - next gate range_out = 1, bcd_out = 0x25, ovf = 0.
  - Then fin period 400 clk → next result has MSD 0, following gate range_out = 0, bcd_out = 0x02 or 0x03.
- hold = 1 across two gates → bcd_out frozen and no valid pulse. Release hold → the next gate's result appears with valid.
- rst_n low for 3 cycles mid-gate → all outputs 0 immediately. The first valid arrives only after a complete new gate (>= 1000 clk after release).
- range_in 0→1 mid-gate, manual → the current gate completes at range 0 (range_out = 0); the next result has range_out = 1 and is ~1/10 of the count.
